cpu_bus_sequencer: RTL and testbench
====================================

CPU_BUS_SEQUENCER -- requirements
Module: cpu_bus_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): WS_IO, 0, wait cycles for I/O access; WS_CRAM, 0, wait cycles for colour RAM; WS_VRAM, 1, wait cycles for tile VRAM; WS_OBJ, 2, wait cycles for sprite/object RAM; all 0..7.
REQ-002 SHALL have ports (name, direction, width, meaning): clk in 1 system clock; rst_n in 1 asynchronous active-low reset; as_n in 1 CPU address strobe; rw in 1 CPU read(1)/write(0); addr in 16 CPU address; din in 8 CPU write data; dec_io_n, dec_cram_n, dec_vram_n, dec_obj_n in 1 each, decoded region selects from the address decoder; vid_req in 1 video scan VRAM request; vid_gnt out 1 video owns VRAM; io_cs_n, cram_cs_n, vram_cs_n, obj_cs_n out 1 each, sequenced strobes; cpu_ready out 1 cycle-complete to CPU; woco, rmrd, init out 1 each, control latch bits; bus_err out 1 timeout pulse.

Function
REQ-003 FSM states SHALL be IDLE, ARB, ACCESS, HOLD; the encoding is free.
REQ-004 IDLE: as_n sampled low with exactly one dec_*_n low SHALL latch the region and go to ARB; as_n low with no select low SHALL go straight to HOLD with cpu_ready=1 (open-bus cycle).
REQ-005 More than one dec_*_n low SHALL be resolved by the fixed priority IO > CRAM > OBJ > VRAM.
REQ-006 ARB: a non-VRAM region SHALL go to ACCESS on the next cycle; a VRAM region SHALL go to ACCESS only when vid_gnt=0 and vid_req=0, otherwise it stays in ARB.
REQ-007 ACCESS: the matching *_cs_n SHALL be driven low from ACCESS entry; a 3-bit counter loaded with WS_<region> SHALL decrement each cycle; at 0, cpu_ready SHALL be set to 1 and the FSM SHALL go to HOLD.
REQ-008 Minimum latency SHALL be 3 clocks from the as_n-low sample to cpu_ready=1 when WS=0; each wait state SHALL add one clock.
REQ-009 HOLD: the strobe and cpu_ready SHALL be held until as_n is sampled high; then all strobes go high, cpu_ready goes 0 and the FSM returns to IDLE in the same cycle.
REQ-010 vid_gnt SHALL rise the cycle after vid_req=1 only while the FSM is not in ACCESS or HOLD with region VRAM; it SHALL fall the cycle after vid_req=0.
REQ-011 vram_cs_n and vid_gnt SHALL never be active in the same cycle.
REQ-012 Starvation rule: when vid_gnt falls while a CPU VRAM cycle waits in ARB, the CPU SHALL get ACCESS before vid_gnt may rise again.
REQ-013 A write (rw=0) to addr 0x5F88 completing in ACCESS with region IO SHALL latch woco=din[0], rmrd=din[5], init=din[6] on the cycle cpu_ready rises.
REQ-014 as_n rising before ACCESS completes SHALL abort the cycle, release all strobes the next cycle, return to IDLE and leave the latch unchanged.
REQ-015 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE, the counter to 0, all *_cs_n=1, cpu_ready=0, vid_gnt=0, woco=rmrd=init=0 and bus_err=0.
REQ-017 Reset asserted mid-cycle SHALL drop the strobes immediately; after release the first as_n-low sample SHALL start a fresh cycle.

Configuration
REQ-018 Macro ACCESS_TIMEOUT_EN SHALL control the timeout. Defined: an 8-bit counter runs in ARB/ACCESS/HOLD, and at 255 cycles it forces IDLE, releases the strobes and pulses bus_err high for 1 clock. Undefined: no counter is built and bus_err is tied 0.

Verification
REQ-019 CPU read at 0x5F80, dec_io_n=0, WS_IO=0 -> io_cs_n low from clock 2, cpu_ready=1 at clock 3, released 1 clock after as_n high.
REQ-020 CPU write 0x61 to 0x5F88 -> woco=1, rmrd=1, init=1; a subsequent write of 0x00 -> all three 0.
REQ-021 CPU VRAM access at 0x4000 while vid_req=1 -> CPU held in ARB, vram_cs_n=1; vid_req drops -> vram_cs_n low 2 clocks later, ready after 1 wait cycle, vid_gnt blocked until HOLD exits.
REQ-022 Object access at 0x7C00, WS_OBJ=2, as_n released in ACCESS after 1 cycle -> abort, obj_cs_n high next clock, cpu_ready never 1.
REQ-023 Pulse rst_n low during an ACCESS -> all strobes high asynchronously, latch 0; next cycle normal.
REQ-024 With ACCESS_TIMEOUT_EN, as_n held low 300 clocks -> bus_err single pulse at clock 255, strobes released.

Source files
------------

// File: rtl/cpu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_sequencer
// Purpose  : Sequences CPU bus cycles onto four decoded memory/IO regions
//            (IO, colour RAM, tile VRAM, sprite/object RAM). Each region
//            has its own number of wait states. CPU VRAM cycles are
//            arbitrated against the video scan-out. A write-only control
//            latch at 0x5F88 is also held here.
//
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            as_n, rw, addr, din - CPU strobe, direction, address, write data
//            dec_*_n             - region selects from the address decoder
//            vid_req / vid_gnt   - video scan VRAM request / grant
//            *_cs_n              - sequenced region chip selects
//            cpu_ready           - cycle complete, held until as_n rises
//            woco, rmrd, init    - control latch bits (din[0], din[5], din[6])
//            bus_err             - one-clock timeout pulse
//
// Options  : ACCESS_TIMEOUT_EN - when defined, builds a 255-cycle bus
//            watchdog that forces IDLE and pulses bus_err. When undefined,
//            bus_err is tied low.
//
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_sequencer #(
    parameter int unsigned WS_IO   = 0,
    parameter int unsigned WS_CRAM = 0,
    parameter int unsigned WS_VRAM = 1,
    parameter int unsigned WS_OBJ  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        as_n,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    input  logic        dec_io_n,
    input  logic        dec_cram_n,
    input  logic        dec_vram_n,
    input  logic        dec_obj_n,
    input  logic        vid_req,
    output logic        vid_gnt,
    output logic        io_cs_n,
    output logic        cram_cs_n,
    output logic        vram_cs_n,
    output logic        obj_cs_n,
    output logic        cpu_ready,
    output logic        woco,
    output logic        rmrd,
    output logic        init,
    output logic        bus_err
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_arb    = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_hold   = 2'd3;

    // Region codes double as the bit index into the chip-select vector
    localparam logic [1:0] c_rg_io   = 2'd0;
    localparam logic [1:0] c_rg_cram = 2'd1;
    localparam logic [1:0] c_rg_vram = 2'd2;
    localparam logic [1:0] c_rg_obj  = 2'd3;

    localparam logic [2:0]  c_ws_io     = 3'(WS_IO);
    localparam logic [2:0]  c_ws_cram   = 3'(WS_CRAM);
    localparam logic [2:0]  c_ws_vram   = 3'(WS_VRAM);
    localparam logic [2:0]  c_ws_obj    = 3'(WS_OBJ);
    localparam logic [15:0] c_ctrl_addr = 16'h5F88;

    logic [1:0] r_state;
    logic [1:0] r_region;
    logic [2:0] r_wait;
    logic [3:0] r_cs_n;
    logic       r_cpu_ready;
    logic       r_vid_gnt;
    logic       r_vprio;
    logic       r_woco;
    logic       r_rmrd;
    logic       r_init;

    logic [1:0] w_state_nxt;
    logic [1:0] w_region_nxt;
    logic [2:0] w_wait_nxt;
    logic [3:0] w_cs_n_nxt;
    logic       w_ready_nxt;
    logic       w_vprio_nxt;
    logic       w_gnt_nxt;
    logic       w_latch_en;
    logic       w_any_sel;
    logic [1:0] w_sel_region;
    logic [2:0] w_region_ws;
    logic       w_arb_go;
    logic       w_gnt_block;
    logic       w_timeout;
    logic       w_unused;

    // Only din[0], din[5] and din[6] are used by the control latch
    assign w_unused = &{1'b0, din[7], din[4:1]};

    assign w_any_sel = ~(dec_io_n & dec_cram_n & dec_vram_n & dec_obj_n);

    // Fixed priority when the decoder asserts several selects at once
    always_comb begin
        if (!dec_io_n)        w_sel_region = c_rg_io;
        else if (!dec_cram_n) w_sel_region = c_rg_cram;
        else if (!dec_obj_n)  w_sel_region = c_rg_obj;
        else                  w_sel_region = c_rg_vram;
    end

    always_comb begin
        case (r_region)
            c_rg_io:   w_region_ws = c_ws_io;
            c_rg_cram: w_region_ws = c_ws_cram;
            c_rg_vram: w_region_ws = c_ws_vram;
            default:   w_region_ws = c_ws_obj;
        endcase
    end

    // VRAM needs the video side idle. Once the CPU has been made to wait
    // out a grant (r_vprio), it no longer waits for vid_req to be low, so
    // a video request arriving again right away cannot starve the CPU.
    assign w_arb_go = (r_region != c_rg_vram) ||
                      (!r_vid_gnt && (!vid_req || r_vprio));

    // The grant stays low while the CPU owns VRAM, and also while a starved
    // CPU VRAM cycle is being pushed through arbitration.
    assign w_gnt_block = r_vprio ||
                         (((r_state == c_st_access) || (r_state == c_st_hold)) &&
                          (r_region == c_rg_vram));
    assign w_gnt_nxt   = vid_req && !w_gnt_block;

    always_comb begin
        w_state_nxt  = r_state;
        w_region_nxt = r_region;
        w_wait_nxt   = r_wait;
        w_cs_n_nxt   = r_cs_n;
        w_ready_nxt  = r_cpu_ready;
        w_vprio_nxt  = r_vprio;
        w_latch_en   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!as_n) begin
                    if (w_any_sel) begin
                        w_state_nxt  = c_st_arb;
                        w_region_nxt = w_sel_region;
                    end else begin
                        // Open-bus cycle. The region is parked on IO so a
                        // stale VRAM region cannot block the video grant.
                        w_state_nxt  = c_st_hold;
                        w_region_nxt = c_rg_io;
                        w_ready_nxt  = 1'b1;
                    end
                end
            end
            c_st_arb: begin
                if (as_n) begin
                    w_state_nxt = c_st_idle;
                    w_vprio_nxt = 1'b0;
                end else if (w_arb_go) begin
                    w_state_nxt = c_st_access;
                    w_wait_nxt  = w_region_ws;
                    w_cs_n_nxt  = ~(4'b0001 << r_region);
                    w_vprio_nxt = 1'b0;
                end else if (r_vid_gnt && !vid_req) begin
                    w_vprio_nxt = 1'b1;
                end
            end
            c_st_access: begin
                if (as_n) begin
                    // CPU gave up before completion: abort, latch untouched
                    w_state_nxt = c_st_idle;
                    w_cs_n_nxt  = 4'hF;
                    w_wait_nxt  = 3'd0;
                end else if (r_wait == 3'd0) begin
                    w_state_nxt = c_st_hold;
                    w_ready_nxt = 1'b1;
                    w_latch_en  = (r_region == c_rg_io) && !rw && (addr == c_ctrl_addr);
                end else begin
                    w_wait_nxt = r_wait - 3'd1;
                end
            end
            c_st_hold: begin
                if (as_n) begin
                    w_state_nxt = c_st_idle;
                    w_cs_n_nxt  = 4'hF;
                    w_ready_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cs_n_nxt  = 4'hF;
                w_ready_nxt = 1'b0;
                w_wait_nxt  = 3'd0;
                w_vprio_nxt = 1'b0;
            end
        endcase
        if (w_timeout) begin
            w_state_nxt = c_st_idle;
            w_cs_n_nxt  = 4'hF;
            w_ready_nxt = 1'b0;
            w_wait_nxt  = 3'd0;
            w_vprio_nxt = 1'b0;
            w_latch_en  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_region    <= c_rg_io;
            r_wait      <= 3'd0;
            r_cs_n      <= 4'hF;
            r_cpu_ready <= 1'b0;
            r_vid_gnt   <= 1'b0;
            r_vprio     <= 1'b0;
            r_woco      <= 1'b0;
            r_rmrd      <= 1'b0;
            r_init      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_region    <= w_region_nxt;
            r_wait      <= w_wait_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_cpu_ready <= w_ready_nxt;
            r_vid_gnt   <= w_gnt_nxt;
            r_vprio     <= w_vprio_nxt;
            if (w_latch_en) begin
                r_woco <= din[0];
                r_rmrd <= din[5];
                r_init <= din[6];
            end
        end
    end

`ifdef ACCESS_TIMEOUT_EN
    // Counter is preloaded to 1 while idle, so reaching 254 marks the
    // 255th clock spent outside IDLE.
    localparam logic [7:0] c_to_limit = 8'd254;

    logic [7:0] r_to_cnt;
    logic       r_bus_err;

    assign w_timeout = (r_state != c_st_idle) && (r_to_cnt == c_to_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= 8'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if ((r_state == c_st_idle) || w_timeout) r_to_cnt <= 8'd1;
            else                                     r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    assign io_cs_n   = r_cs_n[c_rg_io];
    assign cram_cs_n = r_cs_n[c_rg_cram];
    assign vram_cs_n = r_cs_n[c_rg_vram];
    assign obj_cs_n  = r_cs_n[c_rg_obj];
    assign cpu_ready = r_cpu_ready;
    assign vid_gnt   = r_vid_gnt;
    assign woco      = r_woco;
    assign rmrd      = r_rmrd;
    assign init      = r_init;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus_sequencer
// Purpose  : Self-checking bench for cpu_bus_sequencer. Uses directed
//            vectors, hand-written multi-cycle sequences and random
//            transactions, all checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_sequencer;

    localparam int WS_IO   = 0;
    localparam int WS_CRAM = 3;
    localparam int WS_VRAM = 1;
    localparam int WS_OBJ  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        as_n = 1'b1;
    logic        rw = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic        dec_io_n = 1'b1, dec_cram_n = 1'b1, dec_vram_n = 1'b1, dec_obj_n = 1'b1;
    logic        vid_req = 1'b0;
    logic        vid_gnt, io_cs_n, cram_cs_n, vram_cs_n, obj_cs_n;
    logic        cpu_ready, woco, rmrd, init, bus_err;

    cpu_bus_sequencer #(
        .WS_IO(WS_IO), .WS_CRAM(WS_CRAM), .WS_VRAM(WS_VRAM), .WS_OBJ(WS_OBJ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .as_n(as_n), .rw(rw), .addr(addr), .din(din),
        .dec_io_n(dec_io_n), .dec_cram_n(dec_cram_n), .dec_vram_n(dec_vram_n),
        .dec_obj_n(dec_obj_n), .vid_req(vid_req), .vid_gnt(vid_gnt),
        .io_cs_n(io_cs_n), .cram_cs_n(cram_cs_n), .vram_cs_n(vram_cs_n),
        .obj_cs_n(obj_cs_n), .cpu_ready(cpu_ready), .woco(woco), .rmrd(rmrd),
        .init(init), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dec / strobe masks: bit0 IO, bit1 CRAM, bit2 VRAM, bit3 OBJ (active-high)
    typedef struct {
        logic [3:0]  dec;
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  din;
        int          abort_k;
        logic [3:0]  exp_cs;
        int          exp_lat;
        logic [2:0]  exp_latch;
    } vec_t;

    vec_t vecs[16];
    logic [2:0] model_latch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] strobes();
        return ~{obj_cs_n, vram_cs_n, cram_cs_n, io_cs_n};
    endfunction

    // Model: fixed priority IO > CRAM > OBJ > VRAM, -1 for open bus
    function automatic int winner(input logic [3:0] d);
        if (d[0]) return 0;
        if (d[1]) return 1;
        if (d[3]) return 3;
        if (d[2]) return 2;
        return -1;
    endfunction

    function automatic int ws_of(input int r);
        case (r)
            0: return WS_IO;
            1: return WS_CRAM;
            2: return WS_VRAM;
            default: return WS_OBJ;
        endcase
    endfunction

    task automatic set_dec(input logic [3:0] d);
        {dec_obj_n, dec_vram_n, dec_cram_n, dec_io_n} = ~d;
    endtask

    // One CPU cycle with vid_req low. Strobe expected from clock 2, ready
    // from clock exp_lat (0 = never). abort_k > 0 raises as_n after that clock.
    task automatic run_txn(input logic [3:0] d, input logic rwv, input logic [15:0] a,
                           input logic [7:0] dv, input int abort_k, input logic [3:0] exp_cs,
                           input int exp_lat, input int extra, input string tag);
        int last;
        as_n = 1'b0; rw = rwv; addr = a; din = dv;
        set_dec(d);
        last = (abort_k > 0) ? abort_k : exp_lat + extra;
        for (int n = 1; n <= last; n++) begin
            step();
            chk({tag, "_cs"}, 32'(strobes()), 32'((n >= 2) ? exp_cs : 4'b0000));
            chk({tag, "_rdy"}, 32'(cpu_ready), 32'((exp_lat > 0) && (n >= exp_lat)));
        end
        as_n = 1'b1;
        set_dec(4'b0000);
        step();
        chk({tag, "_rel_cs"}, 32'(strobes()), 32'h0);
        chk({tag, "_rel_rdy"}, 32'(cpu_ready), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'b0001, 1'b1, 16'h5F80, 8'h00, 0, 4'b0001, 3, 3'b000};
        vecs[1]  = '{4'b0001, 1'b0, 16'h5F88, 8'h61, 0, 4'b0001, 3, 3'b111};
        vecs[2]  = '{4'b0001, 1'b0, 16'h5F88, 8'h00, 0, 4'b0001, 3, 3'b000};
        vecs[3]  = '{4'b0001, 1'b0, 16'h5F88, 8'h41, 0, 4'b0001, 3, 3'b101};
        vecs[4]  = '{4'b0010, 1'b0, 16'h5F88, 8'h20, 0, 4'b0010, 6, 3'b101};
        vecs[5]  = '{4'b0100, 1'b1, 16'h4000, 8'h00, 0, 4'b0100, 4, 3'b101};
        vecs[6]  = '{4'b1000, 1'b1, 16'h7C00, 8'h00, 0, 4'b1000, 5, 3'b101};
        vecs[7]  = '{4'b0101, 1'b1, 16'h4001, 8'h00, 0, 4'b0001, 3, 3'b101};
        vecs[8]  = '{4'b1010, 1'b1, 16'h7C01, 8'h00, 0, 4'b0010, 6, 3'b101};
        vecs[9]  = '{4'b1100, 1'b1, 16'h7C02, 8'h00, 0, 4'b1000, 5, 3'b101};
        vecs[10] = '{4'b1111, 1'b1, 16'h5F80, 8'h00, 0, 4'b0001, 3, 3'b101};
        vecs[11] = '{4'b0000, 1'b1, 16'hFFFF, 8'h00, 0, 4'b0000, 1, 3'b101};
        vecs[12] = '{4'b1000, 1'b1, 16'h7C00, 8'h00, 3, 4'b1000, 0, 3'b101};
        vecs[13] = '{4'b0001, 1'b0, 16'h5F88, 8'h00, 1, 4'b0001, 0, 3'b101};
        vecs[14] = '{4'b0001, 1'b0, 16'h5F88, 8'h00, 0, 4'b0001, 3, 3'b000};
        vecs[15] = '{4'b0001, 1'b0, 16'h5F89, 8'h61, 0, 4'b0001, 3, 3'b000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 32'(strobes()), 32'h0);
        chk("rst_rdy", 32'(cpu_ready), 32'h0);
        chk("rst_gnt", 32'(vid_gnt), 32'h0);
        chk("rst_latch", 32'({woco, rmrd, init}), 32'h0);
        chk("rst_err", 32'(bus_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            run_txn(vecs[i].dec, vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].abort_k,
                    vecs[i].exp_cs, vecs[i].exp_lat, int'($urandom_range(0, 2)),
                    $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_latch", i), 32'({woco, rmrd, init}), 32'(vecs[i].exp_latch));
        end
        model_latch = 3'b000;

        // VRAM cycle behind a video grant; video asks again right after releasing
        vid_req = 1'b1;
        step();
        chk("v_gnt_on", 32'(vid_gnt), 32'h1);
        as_n = 1'b0; rw = 1'b1; addr = 16'h4000; set_dec(4'b0100);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("v_arb_cs", 32'(vram_cs_n), 32'h1);
            chk("v_arb_gnt", 32'(vid_gnt), 32'h1);
        end
        vid_req = 1'b0;
        step();
        chk("v_fall_gnt", 32'(vid_gnt), 32'h0);
        chk("v_fall_cs", 32'(vram_cs_n), 32'h1);
        vid_req = 1'b1;
        step();
        chk("v_acc_cs", 32'(vram_cs_n), 32'h0);
        chk("v_acc_gnt", 32'(vid_gnt), 32'h0);
        chk("v_acc_rdy", 32'(cpu_ready), 32'h0);
        step();
        chk("v_ws_rdy", 32'(cpu_ready), 32'h0);
        chk("v_ws_gnt", 32'(vid_gnt), 32'h0);
        step();
        chk("v_rdy", 32'(cpu_ready), 32'h1);
        chk("v_rdy_cs", 32'(vram_cs_n), 32'h0);
        chk("v_rdy_gnt", 32'(vid_gnt), 32'h0);
        step();
        chk("v_hold_gnt", 32'(vid_gnt), 32'h0);
        as_n = 1'b1; set_dec(4'b0000);
        step();
        chk("v_rel_cs", 32'(vram_cs_n), 32'h1);
        chk("v_rel_gnt", 32'(vid_gnt), 32'h0);
        step();
        chk("v_regnt", 32'(vid_gnt), 32'h1);
        vid_req = 1'b0;
        step();
        chk("v_gnt_off", 32'(vid_gnt), 32'h0);

        // Asynchronous reset in the middle of an ACCESS
        run_txn(4'b0001, 1'b0, 16'h5F88, 8'h61, 0, 4'b0001, 3, 0, "pre_rst");
        chk("pre_rst_latch", 32'({woco, rmrd, init}), 32'h7);
        as_n = 1'b0; rw = 1'b1; addr = 16'h7C00; set_dec(4'b1000);
        step();
        step();
        chk("mid_cs", 32'(obj_cs_n), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cs", 32'(strobes()), 32'h0);
        chk("ar_rdy", 32'(cpu_ready), 32'h0);
        chk("ar_latch", 32'({woco, rmrd, init}), 32'h0);
        chk("ar_gnt", 32'(vid_gnt), 32'h0);
        as_n = 1'b1; set_dec(4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(4'b0001, 1'b1, 16'h5F80, 8'h00, 0, 4'b0001, 3, 1, "post_rst");
        model_latch = 3'b000;

        // Random transactions against the transaction-level model
        for (int t = 0; t < 40; t++) begin
            logic [3:0]  d;
            logic        rwv;
            logic [15:0] a;
            logic [7:0]  dv;
            logic [3:0]  cs;
            int          r, lat, ab;
            d   = 4'($urandom_range(0, 15));
            rwv = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 1) == 0) ? 16'h5F88 : 16'($urandom);
            dv  = 8'($urandom);
            r   = winner(d);
            lat = (r < 0) ? 1 : 3 + ws_of(r);
            cs  = 4'b0000;
            if (r >= 0) cs[r] = 1'b1;
            ab  = 0;
            if ((r >= 0) && ($urandom_range(0, 3) == 0)) ab = int'($urandom_range(1, lat - 1));
            run_txn(d, rwv, a, dv, ab, cs, (ab > 0) ? 0 : lat,
                    int'($urandom_range(0, 2)), "rnd");
            if ((ab == 0) && (r == 0) && !rwv && (a == 16'h5F88))
                model_latch = {dv[0], dv[5], dv[6]};
            chk("rnd_latch", 32'({woco, rmrd, init}), 32'(model_latch));
        end

        // VRAM cycles with random video traffic: grant/strobe exclusion
        for (int t = 0; t < 10; t++) begin
            logic prev_req;
            logic got;
            int   waited;
            as_n = 1'b0; rw = 1'b1; addr = 16'h4000 + 16'(t); set_dec(4'b0100);
            got = 1'b0;
            waited = 0;
            while (!got && (waited < 200)) begin
                prev_req = vid_req;
                step();
                waited++;
                chk("rv_excl", 32'(!vram_cs_n && vid_gnt), 32'h0);
                if (!prev_req) chk("rv_gnt_fall", 32'(vid_gnt), 32'h0);
                if (cpu_ready) got = 1'b1;
                vid_req = 1'($urandom_range(0, 1));
            end
            chk("rv_done", 32'(got), 32'h1);
            chk("rv_cs_at_rdy", 32'(vram_cs_n), 32'h0);
            as_n = 1'b1; set_dec(4'b0000);
            step();
            chk("rv_rel_cs", 32'(vram_cs_n), 32'h1);
            chk("rv_rel_excl", 32'(!vram_cs_n && vid_gnt), 32'h0);
        end
        vid_req = 1'b0;
        step();
        step();

        // as_n held low for 300 clocks
        begin
            int pulses;
            int first;
            pulses = 0;
            first = -1;
            as_n = 1'b0; rw = 1'b1; addr = 16'h5F80; set_dec(4'b0001);
            for (int n = 1; n <= 300; n++) begin
                step();
                if (bus_err) begin
                    pulses++;
                    if (first < 0) first = n;
                end
`ifdef ACCESS_TIMEOUT_EN
                if (n == 254) chk("to_cs_before", 32'(io_cs_n), 32'h0);
                if (n == 255) begin
                    chk("to_cs_rel", 32'(io_cs_n), 32'h1);
                    chk("to_rdy_rel", 32'(cpu_ready), 32'h0);
                end
`endif
            end
`ifdef ACCESS_TIMEOUT_EN
            chk("to_pulses", 32'(pulses), 32'h1);
            chk("to_first", 32'(first), 32'd255);
`else
            chk("noto_pulses", 32'(pulses), 32'h0);
            chk("noto_rdy", 32'(cpu_ready), 32'h1);
            chk("noto_cs", 32'(io_cs_n), 32'h0);
`endif
            as_n = 1'b1; set_dec(4'b0000);
            step();
            step();
            chk("end_cs", 32'(strobes()), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
